// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station and the instruction unit.
package alu_reservation_station_pkg;

  localparam int RESULT_W = 32;

  // Opcode encodings, shared with the instruction unit decoder
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;
  localparam int OP_OR  = 3;
  localparam int OP_AND = 4;
  localparam int OP_SLL = 5;
  localparam int OP_SRL = 6;
  localparam int OP_SRA = 7;
  localparam int OP_EQ  = 8;
  localparam int OP_NE  = 9;
  localparam int OP_LT  = 10;
  localparam int OP_LTU = 11;

  // Low bit of channel k inside a packed CDB bus of per-channel width w
  function automatic int cdbLsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/alu_reservation_station_exec.sv
// One-stage integer ALU; purely combinational.
module alu_exec
  import alu_reservation_station_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]     op,
  input  logic [RESULT_W-1:0] v1,
  input  logic [RESULT_W-1:0] v2,
  output logic [RESULT_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = v2[4:0];

  // Opcode decode; unused encodings produce zero
  always_comb begin
    result = '0;
    case (int'(op))
      OP_ADD: result = v1 + v2;
      OP_SUB: result = v1 - v2;
      OP_XOR: result = v1 ^ v2;
      OP_OR:  result = v1 | v2;
      OP_AND: result = v1 & v2;
      OP_SLL: result = v1 << shamt;
      OP_SRL: result = v1 >> shamt;
      OP_SRA: result = $unsigned($signed(v1) >>> shamt);
      OP_EQ:  result = RESULT_W'(v1 == v2);
      OP_NE:  result = RESULT_W'(v1 != v2);
      OP_LT:  result = RESULT_W'($signed(v1) < $signed(v2));
      OP_LTU: result = RESULT_W'(v1 < v2);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_reservation_station_prio.sv
// Lowest-index-first priority encoder, one grant term per request bit.
module rs_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [N-1:0] grant;

  // Bit g wins only when no lower-index bit is requesting
  for (genvar g = 0; g < N; g++) begin : gGrant
    localparam logic [N-1:0] LOW = (N'(1) << g) - N'(1);
    assign grant[g] = req[g] & ~|(req & LOW);
  end

  assign any = |req;

  // One-hot grant to binary index
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) idx = idx | W'(i);
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ops until operands arrive, issues oldest-index ready.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_OP_WIDTH = 4,
  parameter int RS_WIDTH    = 4,
  parameter int ROB_WIDTH   = 4,
  parameter int CDB_PORTS   = 2,
  parameter int FULL_MARGIN = 2
) (
  input  logic                            clockIn,
  input  logic                            resetIn,
  input  logic                            flushIn,
  input  logic                            addValid,
  input  logic [RS_OP_WIDTH-1:0]          addOp,
  input  logic [ROB_WIDTH-1:0]            addRobIndex,
  input  logic [RESULT_W-1:0]             addVal1,
  input  logic [RESULT_W-1:0]             addVal2,
  input  logic                            addHasDep1,
  input  logic                            addHasDep2,
  input  logic [ROB_WIDTH-1:0]            addConstrt1,
  input  logic [ROB_WIDTH-1:0]            addConstrt2,
  input  logic [CDB_PORTS-1:0]            cdbValid,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0]  cdbRobIndex,
  input  logic [CDB_PORTS*RESULT_W-1:0]   cdbValue,
  output logic                            full,
  output logic [RS_WIDTH:0]               count,
  output logic                            update,
  output logic [ROB_WIDTH-1:0]            updateRobId,
  output logic [RESULT_W-1:0]             updateVal
);

  localparam int DEPTH = 2 ** RS_WIDTH;
  localparam int NSRC  = CDB_PORTS + 1;   // source 0 is the exec stage
  localparam int CNT_W = RS_WIDTH + 1;

  typedef struct packed {
    logic [RS_OP_WIDTH-1:0] op;
    logic [ROB_WIDTH-1:0]   rob;
    logic [RESULT_W-1:0]    v1;
    logic [RESULT_W-1:0]    v2;
    logic                   dep1;
    logic                   dep2;
    logic [ROB_WIDTH-1:0]   tag1;
    logic [ROB_WIDTH-1:0]   tag2;
  } entry_t;

  entry_t                 ent [DEPTH];
  logic [DEPTH-1:0]       entValid;
  logic                   execValid;
  logic [RS_OP_WIDTH-1:0] execOp;
  logic [ROB_WIDTH-1:0]   execRob;
  logic [RESULT_W-1:0]    execV1, execV2, execResult;

  logic [NSRC-1:0]                srcValid;
  logic [NSRC-1:0][ROB_WIDTH-1:0] srcTag;
  logic [NSRC-1:0][RESULT_W-1:0]  srcVal;
  logic [RESULT_W:0]              wake1 [DEPTH];
  logic [RESULT_W:0]              wake2 [DEPTH];
  logic [RESULT_W:0]              addWake1, addWake2;
  logic [DEPTH-1:0]               readyVec;
  logic                           freeAny, selAny, addFire, issue;
  logic [RS_WIDTH-1:0]            freeIdx, selIdx;

  // {hit, value} for a tag; lower source index has priority
  function automatic logic [RESULT_W:0] lookup(
    input logic [ROB_WIDTH-1:0]            tag,
    input logic [NSRC-1:0]                 v,
    input logic [NSRC-1:0][ROB_WIDTH-1:0]  t,
    input logic [NSRC-1:0][RESULT_W-1:0]   d
  );
    lookup = '0;
    for (int s = NSRC - 1; s >= 0; s--)
      if (v[s] && t[s] == tag) lookup = {1'b1, d[s]};
  endfunction

  // Wake-up source table: exec stage first, then the external channels
  always_comb begin
    srcValid[0] = execValid;
    srcTag[0]   = execRob;
    srcVal[0]   = execResult;
    for (int k = 0; k < CDB_PORTS; k++) begin
      srcValid[k+1] = cdbValid[k];
      srcTag[k+1]   = cdbRobIndex[cdbLsb(k, ROB_WIDTH) +: ROB_WIDTH];
      srcVal[k+1]   = cdbValue[cdbLsb(k, RESULT_W) +: RESULT_W];
    end
  end

  // Tag matches for resident entries and the incoming allocation
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]    = lookup(ent[i].tag1, srcValid, srcTag, srcVal);
      wake2[i]    = lookup(ent[i].tag2, srcValid, srcTag, srcVal);
      readyVec[i] = entValid[i] & ~ent[i].dep1 & ~ent[i].dep2;
    end
    addWake1 = lookup(addConstrt1, srcValid, srcTag, srcVal);
    addWake2 = lookup(addConstrt2, srcValid, srcTag, srcVal);
  end

  rs_prio_enc #(.N(DEPTH), .W(RS_WIDTH)) uFree (.req(~entValid), .any(freeAny), .idx(freeIdx));
  rs_prio_enc #(.N(DEPTH), .W(RS_WIDTH)) uSel  (.req(readyVec),  .any(selAny),  .idx(selIdx));

  alu_exec #(.OP_W(RS_OP_WIDTH)) uExec (.op(execOp), .v1(execV1), .v2(execV2), .result(execResult));

  assign addFire = addValid & freeAny & ~flushIn;
  assign issue   = selAny & ~flushIn;
  assign full    = (count >= CNT_W'(DEPTH - FULL_MARGIN));

  // Entry payload: write on allocation (with bypass), otherwise capture broadcasts
  always_ff @(posedge clockIn) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (addFire && freeIdx == RS_WIDTH'(i)) begin
        ent[i].op   <= addOp;
        ent[i].rob  <= addRobIndex;
        ent[i].tag1 <= addConstrt1;
        ent[i].tag2 <= addConstrt2;
        ent[i].dep1 <= addHasDep1 & ~addWake1[RESULT_W];
        ent[i].dep2 <= addHasDep2 & ~addWake2[RESULT_W];
        ent[i].v1   <= (addHasDep1 && addWake1[RESULT_W]) ? addWake1[RESULT_W-1:0] : addVal1;
        ent[i].v2   <= (addHasDep2 && addWake2[RESULT_W]) ? addWake2[RESULT_W-1:0] : addVal2;
      end else begin
        if (ent[i].dep1 && wake1[i][RESULT_W]) begin
          ent[i].v1   <= wake1[i][RESULT_W-1:0];
          ent[i].dep1 <= 1'b0;
        end
        if (ent[i].dep2 && wake2[i][RESULT_W]) begin
          ent[i].v2   <= wake2[i][RESULT_W-1:0];
          ent[i].dep2 <= 1'b0;
        end
      end
    end
  end

  // Occupancy, issue into exec, and the registered result port
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      entValid    <= '0;
      count       <= '0;
      execValid   <= 1'b0;
      execOp      <= '0;
      execRob     <= '0;
      execV1      <= '0;
      execV2      <= '0;
      update      <= 1'b0;
      updateRobId <= '0;
      updateVal   <= '0;
    end else begin
      updateRobId <= execRob;
      updateVal   <= execResult;
      update      <= execValid & ~flushIn;
      execValid   <= issue;
      if (selAny) begin
        execOp  <= ent[selIdx].op;
        execRob <= ent[selIdx].rob;
        execV1  <= ent[selIdx].v1;
        execV2  <= ent[selIdx].v2;
      end
      if (flushIn) begin
        entValid <= '0;
        count    <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (issue && selIdx == RS_WIDTH'(i))        entValid[i] <= 1'b0;
          else if (addFire && freeIdx == RS_WIDTH'(i)) entValid[i] <= 1'b1;
        end
        count <= count + CNT_W'(addFire) - CNT_W'(issue);
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station with directed vectors.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        flushIn = 1'b0;
  logic        addValid = 1'b0;
  logic [3:0]  addOp = '0;
  logic [3:0]  addRobIndex = '0;
  logic [31:0] addVal1 = '0, addVal2 = '0;
  logic        addHasDep1 = 1'b0, addHasDep2 = 1'b0;
  logic [3:0]  addConstrt1 = '0, addConstrt2 = '0;
  logic [1:0]  cdbValid = '0;
  logic [7:0]  cdbRobIndex = '0;
  logic [63:0] cdbValue = '0;
  logic        full;
  logic [4:0]  count;
  logic        update;
  logic [3:0]  updateRobId;
  logic [31:0] updateVal;

  alu_reservation_station #(
    .RS_OP_WIDTH(4), .RS_WIDTH(4), .ROB_WIDTH(4), .CDB_PORTS(2), .FULL_MARGIN(2)
  ) dut (
    .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn),
    .addValid(addValid), .addOp(addOp), .addRobIndex(addRobIndex),
    .addVal1(addVal1), .addVal2(addVal2),
    .addHasDep1(addHasDep1), .addHasDep2(addHasDep2),
    .addConstrt1(addConstrt1), .addConstrt2(addConstrt2),
    .cdbValid(cdbValid), .cdbRobIndex(cdbRobIndex), .cdbValue(cdbValue),
    .full(full), .count(count),
    .update(update), .updateRobId(updateRobId), .updateVal(updateVal)
  );

  always #5 clockIn = ~clockIn;

  typedef struct { logic [3:0] rob; logic [31:0] val; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Monitor: every update pulse must match the oldest expected result
  always @(negedge clockIn) begin : mon
    exp_t e;
    if (resetIn && update) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_update: got rob=%0d val=%h, required no update", updateRobId, updateVal);
      end else begin
        e = q.pop_front();
        if (updateRobId !== e.rob || updateVal !== e.val) begin
          fails++;
          $display("FAIL update_result: got rob=%0d val=%h, required rob=%0d val=%h",
                   updateRobId, updateVal, e.rob, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] val);
    exp_t e;
    e.rob = rob;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic doAlloc(input logic [3:0] op, input logic [3:0] rob,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic d1, input logic [3:0] t1,
                         input logic d2, input logic [3:0] t2);
    addValid = 1'b1; addOp = op; addRobIndex = rob;
    addVal1 = v1; addVal2 = v2;
    addHasDep1 = d1; addConstrt1 = t1;
    addHasDep2 = d2; addConstrt2 = t2;
    tick();
    addValid = 1'b0;
  endtask

  task automatic broadcast(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdbValid = '0;
    cdbValid[ch] = 1'b1;
    cdbRobIndex[ch*4 +: 4] = tag;
    cdbValue[ch*32 +: 32] = val;
    tick();
    cdbValid = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check(name, 32'(q.size()), 32'd0);
  endtask

  logic [3:0]  cOp [12] = '{4'd10, 4'd11, 4'd7, 4'd13, 4'd2, 4'd6, 4'd1, 4'd8, 4'd9, 4'd3, 4'd4, 4'd5};
  logic [31:0] cV1 [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5, 32'hF0F0, 32'h80000000,
                            32'd3, 32'd7, 32'd7, 32'hF0, 32'hF0, 32'd1};
  logic [31:0] cV2 [12] = '{32'd1, 32'd1, 32'd31, 32'd5, 32'h00FF, 32'd4,
                            32'd5, 32'd7, 32'd7, 32'h0F, 32'h3C, 32'd31};
  logic [31:0] cEx [12] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hF00F, 32'h08000000,
                            32'hFFFFFFFE, 32'd1, 32'd0, 32'hFF, 32'h30, 32'h80000000};

  initial begin
    int n;
    // Reset state
    #23;
    check("rst_update", 32'(update), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rob", 32'(updateRobId), 32'd0);
    check("rst_val", updateVal, 32'd0);
    resetIn = 1'b1;
    tick();

    // Independent ADD and its latency
    push(4'd3, 32'd12);
    doAlloc(4'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    check("t1_count_alloc", 32'(count), 32'd1);
    n = 0;
    while (!update && n < 10) begin
      tick();
      n++;
    end
    check("t1_latency", 32'(n), 32'd2);
    check("t1_rob", 32'(updateRobId), 32'd3);
    tick();
    check("t1_update_one_cycle", 32'(update), 32'd0);
    check("t1_count_end", 32'(count), 32'd0);

    // Bypass at allocation from CDB channel 1
    cdbValid = 2'b10;
    cdbRobIndex = {4'd6, 4'd0};
    cdbValue = {32'd100, 32'd0};
    push(4'd4, 32'd99);
    doAlloc(4'd1, 4'd4, 32'hDEAD, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0);
    cdbValid = '0;
    drain("t2_drain");

    // Chained wake-up through the exec stage
    push(4'd1, 32'd5);
    push(4'd2, 32'd10);
    doAlloc(4'd0, 4'd1, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    doAlloc(4'd5, 4'd2, 32'd0, 32'd33, 1'b1, 4'd1, 1'b0, 4'd0);
    drain("t3_drain");

    // Fill to DEPTH, full threshold, dropped 17th add, then mass wake-up
    for (int i = 0; i < 16; i++) begin
      doAlloc(4'd0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0);
      if (i == 12) check("t4_full_at_13", 32'(full), 32'd0);
      if (i == 13) check("t4_full_at_14", 32'(full), 32'd1);
    end
    check("t4_count_16", 32'(count), 32'd16);
    doAlloc(4'd0, 4'd15, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("t4_drop_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) push(4'(i), 32'd1000 + 32'(i));
    broadcast(0, 4'd9, 32'd1000);
    drain("t4_drain");
    check("t4_count_end", 32'(count), 32'd0);

    // Flush with four pending entries and one op in exec
    for (int i = 0; i < 4; i++)
      doAlloc(4'd0, 4'(8 + i), 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0);
    doAlloc(4'd0, 4'd12, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    check("t5_count_pre", 32'(count), 32'd4);
    flushIn = 1'b1;
    addValid = 1'b1; addOp = 4'd0; addRobIndex = 4'd13;
    addHasDep1 = 1'b0; addHasDep2 = 1'b0;
    tick();
    flushIn = 1'b0;
    addValid = 1'b0;
    check("t5_update_after_flush", 32'(update), 32'd0);
    check("t5_count_after_flush", 32'(count), 32'd0);
    broadcast(0, 4'd5, 32'd77);
    repeat (8) tick();
    check("t5_count_end", 32'(count), 32'd0);

    // ALU corners, one op per cycle
    for (int i = 0; i < 12; i++) begin
      push(4'(i), cEx[i]);
      doAlloc(cOp[i], 4'(i), cV1[i], cV2[i], 1'b0, 4'd0, 1'b0, 4'd0);
    end
    drain("t6_drain");

    // Asynchronous reset with an op in exec
    doAlloc(4'd0, 4'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    doAlloc(4'd0, 4'd8, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0);
    #2 resetIn = 1'b0;
    #1;
    check("t7_rst_update", 32'(update), 32'd0);
    check("t7_rst_count", 32'(count), 32'd0);
    @(negedge clockIn);
    resetIn = 1'b1;
    repeat (6) tick();
    check("t7_count_end", 32'(count), 32'd0);
    check("final_queue", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
